mandel_engine: RTL and testbench

- Upstream producer for the frame-buffer BRAM write port that the pixel generator reads through port B.
- On a start pulse, sweeps every pixel of an H_RES x V_RES frame in raster order.
- For each pixel, runs the Mandelbrot recurrence z <= z^2 + c in signed fixed point.
- Writes the escape iteration count as an ITER_W-bit word, one BRAM write per pixel.

---
 rtl/mandel_pkg.sv | 31 +++
 rtl/mandel_engine_if.sv | 26 ++
 rtl/mandel_iter_step.sv | 38 +++
 rtl/mandel_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_mandel_engine.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot frame-buffer engine.
// Optional build macro: MANDEL_BULB_SKIP_EN (period-2 bulb skip, see mandel_engine.sv).
package mandel_pkg;

    localparam int unsigned DEF_DW       = 32;
    localparam int unsigned DEF_FRAC     = 28;
    localparam int unsigned DEF_ITER_W   = 7;
    localparam int unsigned DEF_MAX_ITER = 127;
    localparam int unsigned DEF_H_RES    = 640;
    localparam int unsigned DEF_V_RES    = 480;
    localparam int unsigned DEF_AW       = 19;

    // Escape radius squared (4.0) and period-2 bulb radius squared (1/16) at product scale
    localparam logic signed [2*DEF_DW:0] FOUR_SQ = (2*DEF_DW+1)'(4) << (2*DEF_FRAC);
    localparam logic signed [2*DEF_DW:0] BULB_R2 = (2*DEF_DW+1)'(1) << (2*DEF_FRAC-4);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ITER  = 3'd2,
        WRITE = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Counter width that stays at least one bit for degenerate 1-pixel dimensions
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mandel_engine_if.sv
// Control inputs and BRAM port-A write signals of the Mandelbrot engine.
interface mandel_engine_if #(
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 19,
    parameter int unsigned ITER_W = 7
) ();
    logic                 start;
    logic signed [DW-1:0] c_re0;
    logic signed [DW-1:0] c_im0;
    logic signed [DW-1:0] step;
    logic                 wea;
    logic [AW-1:0]        addra;
    logic [ITER_W-1:0]    dina;
    logic                 busy;
    logic                 done;

    modport master (
        output start, c_re0, c_im0, step,
        input  wea, addra, dina, busy, done
    );

    modport slave (
        input  start, c_re0, c_im0, step,
        output wea, addra, dina, busy, done
    );
endinterface

// File: rtl/mandel_iter_step.sv
// One combinational Mandelbrot step: escape test on |z|^2 and z <= z^2 + c.
// Multipliers live here so they map onto DSP blocks apart from the FSM.
module mandel_iter_step
    import mandel_pkg::*;
#(
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned FRAC = DEF_FRAC
) (
    input  logic signed [DW-1:0] i_zr,
    input  logic signed [DW-1:0] i_zi,
    input  logic signed [DW-1:0] i_c_re,
    input  logic signed [DW-1:0] i_c_im,
    output logic signed [DW-1:0] o_zr_c,
    output logic signed [DW-1:0] o_zi_c,
    output logic                 o_escape_c
);
    localparam logic signed [2*DW:0] L_FOUR_SQ = (2*DW+1)'(4) << (2*FRAC);

    logic signed [2*DW-1:0] w_sq_r;
    logic signed [2*DW-1:0] w_sq_i;
    logic signed [2*DW-1:0] w_cross;
    logic signed [2*DW:0]   w_mag;
    logic signed [2*DW:0]   w_diff;

    assign w_sq_r  = i_zr * i_zr;
    assign w_sq_i  = i_zi * i_zi;
    assign w_cross = i_zr * i_zi;

    assign w_mag  = (2*DW+1)'(w_sq_r) + (2*DW+1)'(w_sq_i);
    assign w_diff = (2*DW+1)'(w_sq_r) - (2*DW+1)'(w_sq_i);

    // |z| <= 2 before each update keeps the truncated results inside Q4.28
    assign o_escape_c = (w_mag > L_FOUR_SQ);
    assign o_zr_c     = DW'(w_diff >>> FRAC) + i_c_re;
    // 2*zr*zi >>> FRAC folds into a shift by FRAC-1
    assign o_zi_c     = DW'(w_cross >>> (FRAC-1)) + i_c_im;

endmodule

// File: rtl/mandel_engine.sv
// Mandelbrot frame generator: sweeps the frame in raster order and writes one
// escape-iteration count per pixel into the frame-buffer BRAM port A.
// Optional build macro: MANDEL_BULB_SKIP_EN skips iteration for pixels inside
// the period-2 bulb and writes MAX_ITER directly.
module mandel_engine
    import mandel_pkg::*;
#(
    parameter int unsigned ITER_W   = DEF_ITER_W,
    parameter int unsigned MAX_ITER = DEF_MAX_ITER,
    parameter int unsigned H_RES    = DEF_H_RES,
    parameter int unsigned V_RES    = DEF_V_RES,
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned FRAC     = DEF_FRAC,
    parameter int unsigned AW       = DEF_AW
) (
    input  logic           CLK_100MHz,
    input  logic           reset,
    mandel_engine_if.slave bus
);
    localparam int unsigned XW = cnt_w(H_RES);
    localparam int unsigned YW = cnt_w(V_RES);

    state_t               r_state;
    state_t               w_next;

    logic signed [DW-1:0] r_cre0;
    logic signed [DW-1:0] r_step;
    logic signed [DW-1:0] r_cre;
    logic signed [DW-1:0] r_cim;
    logic signed [DW-1:0] r_zr;
    logic signed [DW-1:0] r_zi;
    logic [ITER_W-1:0]    r_iter;
    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic [AW-1:0]        r_addr;

    logic                 r_wea;
    logic                 r_busy;
    logic                 r_done;
    logic [ITER_W-1:0]    r_dina;

    logic                 w_wea_n;
    logic                 w_busy_n;
    logic                 w_done_n;
    logic [ITER_W-1:0]    w_dina_n;

    logic signed [DW-1:0] w_zr_n;
    logic signed [DW-1:0] w_zi_n;
    logic                 w_escape;
    logic                 w_x_last;
    logic                 w_y_last;
    logic                 w_iter_max;
    logic                 w_in_bulb;

    mandel_iter_step #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_step (
        .i_zr       (r_zr),
        .i_zi       (r_zi),
        .i_c_re     (r_cre),
        .i_c_im     (r_cim),
        .o_zr_c     (w_zr_n),
        .o_zi_c     (w_zi_n),
        .o_escape_c (w_escape)
    );

    assign w_x_last   = (r_x == XW'(H_RES - 1));
    assign w_y_last   = (r_y == YW'(V_RES - 1));
    assign w_iter_max = (r_iter == ITER_W'(MAX_ITER));

`ifdef MANDEL_BULB_SKIP_EN
    // (c_re+1)^2 + c_im^2 < 1/16 at full precision; one guard bit for c_re+1
    localparam logic signed [2*DW+2:0] L_BULB_R2 = (2*DW+3)'(1) << (2*FRAC-4);

    logic signed [DW:0]     w_cr1;
    logic signed [2*DW+1:0] w_cr1_sq;
    logic signed [2*DW-1:0] w_ci_sq;
    logic signed [2*DW+2:0] w_bulb_mag;

    assign w_cr1      = (DW+1)'(r_cre) + ((DW+1)'(1) << FRAC);
    assign w_cr1_sq   = w_cr1 * w_cr1;
    assign w_ci_sq    = r_cim * r_cim;
    assign w_bulb_mag = (2*DW+3)'(w_cr1_sq) + (2*DW+3)'(w_ci_sq);
    assign w_in_bulb  = (w_bulb_mag < L_BULB_R2);
`else
    assign w_in_bulb  = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK_100MHz) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        w_next   = r_state;
        w_wea_n  = 1'b0;
        w_done_n = 1'b0;
        w_busy_n = r_busy;
        w_dina_n = r_dina;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next   = INIT;
                    w_busy_n = 1'b1;
                end
            end
            INIT: begin
                if (w_in_bulb) begin
                    w_next   = WRITE;
                    w_wea_n  = 1'b1;
                    w_dina_n = ITER_W'(MAX_ITER);
                end else begin
                    w_next   = ITER;
                end
            end
            ITER: begin
                // On escape or at the cap the count to write is the current iter
                if (w_escape || w_iter_max) begin
                    w_next   = WRITE;
                    w_wea_n  = 1'b1;
                    w_dina_n = r_iter;
                end
            end
            WRITE: begin
                w_next = NEXT;
            end
            NEXT: begin
                if (w_x_last && w_y_last) begin
                    w_next   = DONE;
                    w_busy_n = 1'b0;
                    w_done_n = 1'b1;
                end else begin
                    w_next   = INIT;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next   = IDLE;
                w_busy_n = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge CLK_100MHz) begin
        if (!reset) begin
            r_wea  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dina <= '0;
        end else begin
            r_wea  <= w_wea_n;
            r_busy <= w_busy_n;
            r_done <= w_done_n;
            r_dina <= w_dina_n;
        end
    end

    // Pixel datapath: frame parameters, c stepping, z iteration, raster counters
    always_ff @(posedge CLK_100MHz) begin
        if (!reset) begin
            r_cre0 <= '0;
            r_step <= '0;
            r_cre  <= '0;
            r_cim  <= '0;
            r_zr   <= '0;
            r_zi   <= '0;
            r_iter <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_cre0 <= bus.c_re0;
                        r_step <= bus.step;
                        r_cre  <= bus.c_re0;
                        r_cim  <= bus.c_im0;
                        r_x    <= '0;
                        r_y    <= '0;
                        r_addr <= '0;
                    end
                end
                INIT: begin
                    r_zr   <= '0;
                    r_zi   <= '0;
                    r_iter <= '0;
                end
                ITER: begin
                    if (!(w_escape || w_iter_max)) begin
                        r_zr   <= w_zr_n;
                        r_zi   <= w_zi_n;
                        r_iter <= r_iter + ITER_W'(1);
                    end
                end
                NEXT: begin
                    if (!(w_x_last && w_y_last)) begin
                        r_addr <= r_addr + AW'(1);
                        if (w_x_last) begin
                            r_x   <= '0;
                            r_y   <= r_y + YW'(1);
                            r_cre <= r_cre0;
                            r_cim <= r_cim - r_step;
                        end else begin
                            r_x   <= r_x + XW'(1);
                            r_cre <= r_cre + r_step;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wea   = r_wea;
    assign bus.addra = r_addr;
    assign bus.dina  = r_dina;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_mandel_engine.sv
// Self-checking bench for mandel_engine: a 4x2 frame engine and a 1x1 engine
// compared against a plain-arithmetic Mandelbrot reference.
module tb_mandel_engine;

    localparam int DW    = 32;
    localparam int AW    = 19;
    localparam int IW    = 7;
    localparam int MAXI  = 127;
    localparam int FRAC  = 28;
    localparam int BH    = 4;
    localparam int BV    = 2;
    localparam int NPIX  = BH * BV;
    localparam int ONE   = 1 << FRAC;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mandel_engine_if #(.DW(DW), .AW(AW), .ITER_W(IW)) big_if ();
    mandel_engine_if #(.DW(DW), .AW(AW), .ITER_W(IW)) one_if ();

    mandel_engine #(
        .ITER_W(IW), .MAX_ITER(MAXI), .H_RES(BH), .V_RES(BV),
        .DW(DW), .FRAC(FRAC), .AW(AW)
    ) u_big (
        .CLK_100MHz (clk),
        .reset      (rst_n),
        .bus        (big_if)
    );

    mandel_engine #(
        .ITER_W(IW), .MAX_ITER(MAXI), .H_RES(1), .V_RES(1),
        .DW(DW), .FRAC(FRAC), .AW(AW)
    ) u_one (
        .CLK_100MHz (clk),
        .reset      (rst_n),
        .bus        (one_if)
    );

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } wr_t;

    wr_t q_big[$];
    wr_t q_one[$];
    int  done_big = 0;
    int  done_one = 0;
    int  checks   = 0;
    int  errors   = 0;

    // Write/done monitor, sampled just after the active edge
    always @(posedge clk) begin
        #1;
        if (big_if.wea) q_big.push_back('{32'(big_if.addra), 32'(big_if.dina)});
        if (one_if.wea) q_one.push_back('{32'(one_if.addra), 32'(one_if.dina)});
        if (big_if.done) done_big++;
        if (one_if.done) done_one++;
    end

    // Reference escape count for a single c, using wide plain arithmetic
    function automatic int ref_iter(input int cre, input int cim);
        logic signed [79:0] zr, zi, mag, lim;
        int nzr, nzi;
        zr  = '0;
        zi  = '0;
        lim = 80'sd4 <<< (2 * FRAC);
        for (int it = 0; it <= MAXI; it++) begin
            mag = zr * zr + zi * zi;
            if (mag > lim) return it;
            if (it == MAXI) return MAXI;
            nzr = int'((zr * zr - zi * zi) >>> FRAC) + cre;
            nzi = int'((zr * zi * 80'sd2) >>> FRAC) + cim;
            zr  = 80'(nzr);
            zi  = 80'(nzi);
        end
        return MAXI;
    endfunction

    task automatic wait_done(input bit big, input int d0, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if ((big ? done_big : done_one) > d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_big(input int cre, input int cim, input int st);
        @(negedge clk);
        big_if.c_re0 = cre;
        big_if.c_im0 = cim;
        big_if.step  = st;
        big_if.start = 1'b1;
        @(negedge clk);
        big_if.start = 1'b0;
    endtask

    // Compare a captured 4x2 frame against the reference model
    task automatic check_frame(input int cre0, input int cim0, input int st, input string nm);
        int exp_d;
        checks++;
        if (q_big.size() !== NPIX) begin
            errors++;
            $display("FAIL %s write_count got %0d want %0d", nm, q_big.size(), NPIX);
        end
        for (int i = 0; i < NPIX && i < q_big.size(); i++) begin
            exp_d = ref_iter(cre0 + (i % BH) * st, cim0 - (i / BH) * st);
            checks++;
            if (q_big[i].addr !== 32'(i) || q_big[i].data !== 32'(exp_d)) begin
                errors++;
                $display("FAIL %s pixel %0d got addr=%0d data=%0d want addr=%0d data=%0d",
                         nm, i, q_big[i].addr, q_big[i].data, i, exp_d);
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] obs_b, obs_o;
        rst_n = 1'b0;
        big_if.start = 1'b0; big_if.c_re0 = '0; big_if.c_im0 = '0; big_if.step = '0;
        one_if.start = 1'b0; one_if.c_re0 = '0; one_if.c_im0 = '0; one_if.step = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs_b = {big_if.wea, |big_if.addra, |big_if.dina, big_if.busy, big_if.done};
        obs_o = {one_if.wea, |one_if.addra, |one_if.dina, one_if.busy, one_if.done};
        checks++;
        if (obs_b !== 5'b0) begin
            errors++;
            $display("FAIL reset_big got wea/addr/dina/busy/done=%b want 00000", obs_b);
        end
        checks++;
        if (obs_o !== 5'b0) begin
            errors++;
            $display("FAIL reset_one got wea/addr/dina/busy/done=%b want 00000", obs_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_frame();
        bit ok;
        int d0;
        q_big.delete();
        d0 = done_big;
        start_big(0, 0, 0);
        checks++;
        if (big_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_frame busy_after_start got %b want 1", big_if.busy);
        end
        wait_done(1'b1, d0, ok);
        checks++;
        if (!ok || big_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_frame done_cycle got ok=%0d busy=%b want ok=1 busy=0", ok, big_if.busy);
        end
        @(negedge clk);
        checks++;
        if (big_if.done !== 1'b0 || big_if.busy !== 1'b0 || done_big - d0 !== 1) begin
            errors++;
            $display("FAIL zero_frame after_done got done=%b busy=%b pulses=%0d want 0 0 1",
                     big_if.done, big_if.busy, done_big - d0);
        end
        check_frame(0, 0, 0, "zero_frame");
    endtask

    task automatic test_single_pixel(input int cre, input int cim, input int exp_d, input string nm);
        int lat, obs_d, d0;
        bit seen, ok;
        q_one.delete();
        d0 = done_one;
        @(negedge clk);
        one_if.c_re0 = cre;
        one_if.c_im0 = cim;
        one_if.step  = 0;
        one_if.start = 1'b1;
        lat = 0; seen = 1'b0; obs_d = -1;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(posedge clk);
            #1;
            one_if.start = 1'b0;
            lat++;
            if (one_if.wea) begin
                seen  = 1'b1;
                obs_d = int'(one_if.dina);
            end
        end
        checks++;
        if (!seen || obs_d !== exp_d) begin
            errors++;
            $display("FAIL %s dina got %0d (seen=%0d) want %0d", nm, obs_d, seen, exp_d);
        end
        checks++;
        if (lat !== exp_d + 3) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", nm, lat, exp_d + 3);
        end
        wait_done(1'b0, d0, ok);
        checks++;
        if (!ok || q_one.size() !== 1) begin
            errors++;
            $display("FAIL %s write_count got %0d (done=%0d) want 1", nm, q_one.size(), ok);
        end
    endtask

    task automatic test_random_pixels();
        int cre, cim;
        for (int n = 0; n < 8; n++) begin
            cre = int'($urandom_range(0, 32'h3000_0000)) - 32'sh2200_0000;
            cim = int'($urandom_range(0, 32'h2666_6666)) - 32'sh1333_3333;
            test_single_pixel(cre, cim, ref_iter(cre, cim), "rand_pixel");
        end
    endtask

    task automatic test_random_frames();
        int cre0, cim0, st;
        bit ok;
        for (int n = 0; n < 5; n++) begin
            cre0 = int'($urandom_range(0, 32'h2800_0000)) - 32'sh2000_0000;
            cim0 = int'($urandom_range(0, 32'h2666_6666)) - 32'sh1333_3333;
            st   = int'($urandom_range(0, 32'h0400_0000));
            q_big.delete();
            start_big(cre0, cim0, st);
            wait_done(1'b1, done_big, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rand_frame timeout got no done want done");
            end
            check_frame(cre0, cim0, st, "rand_frame");
        end
    endtask

    task automatic test_back_to_back();
        int cre0, cim0, st, d0;
        bit seen_done, done_start;
        cre0 = -(ONE * 3 / 2);
        cim0 = ONE / 2;
        st   = ONE / 4;
        q_big.delete();
        d0 = done_big;
        start_big(cre0, cim0, st);
        seen_done = 1'b0;
        done_start = 1'b0;
        for (int k = 0; k < 3000 && !seen_done; k++) begin
            if (big_if.done) begin
                big_if.start = 1'b1;
                done_start = 1'b1;
                seen_done = 1'b1;
            end else begin
                big_if.start = ($urandom_range(0, 2) == 0);
            end
            @(negedge clk);
        end
        big_if.start = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (!done_start || done_big - d0 !== 1 || big_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back restart got done_seen=%0d pulses=%0d busy=%b want 1 1 0",
                     done_start, done_big - d0, big_if.busy);
        end
        check_frame(cre0, cim0, st, "back_to_back");
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        logic [2:0] obs;
        int addr_before;
        q_big.delete();
        start_big(0, 0, 0);
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            if (q_big.size() >= 3) ok = 1'b1;
        end
        repeat (10) @(negedge clk);
        addr_before = int'(big_if.addra);
        rst_n = 1'b0;
        @(negedge clk);
        obs = {big_if.wea, big_if.busy, |big_if.addra};
        checks++;
        if (!ok || addr_before !== 3 || obs !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid got ok=%0d addr_before=%0d wea/busy/addr=%b want 1 3 000",
                     ok, addr_before, obs);
        end
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (q_big.size() !== 3 || big_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid quiet got writes=%0d busy=%b want 3 0", q_big.size(), big_if.busy);
        end
        q_big.delete();
        start_big(0, 0, 0);
        wait_done(1'b1, done_big, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_mid rerun got no done want done");
        end
        check_frame(0, 0, 0, "reset_mid_rerun");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_frame();
        test_single_pixel(2 * ONE, 0, 2, "c_2p0");
        test_single_pixel(ONE, 0, 3, "c_1p0");
        test_single_pixel(-2 * ONE, 0, MAXI, "c_m2p0");
        test_single_pixel(-ONE, 0, MAXI, "c_m1p0");
        test_random_pixels();
        test_random_frames();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
